// File: rtl/mmu_wb_master_pkg.sv
// mmu_wb_master_pkg
// Shared definitions for the MMU-side Wishbone master:
//   - state_t       : controller state encoding (also exported on dbg_state)
//   - WB_SELECT_*   : one-hot slave select codes produced by the TLB
//   - ZeroWord      : all-zero data word
//   - WB_ADDR_W / WB_DATA_W / WB_SEL_W / WB_SLAVE_W : bus widths
package mmu_wb_master_pkg;

    localparam int WB_ADDR_W  = 32;
    localparam int WB_DATA_W  = 32;
    localparam int WB_SEL_W   = 4;
    localparam int WB_SLAVE_W = 16;

    localparam logic [WB_DATA_W-1:0] ZeroWord = 32'h0000_0000;

    localparam logic [WB_SLAVE_W-1:0] WB_SELECT_RAM   = 16'h0001;
    localparam logic [WB_SLAVE_W-1:0] WB_SELECT_ROM   = 16'h0002;
    localparam logic [WB_SLAVE_W-1:0] WB_SELECT_UART  = 16'h0004;
    localparam logic [WB_SLAVE_W-1:0] WB_SELECT_GPIO  = 16'h0008;
    localparam logic [WB_SLAVE_W-1:0] WB_SELECT_TIMER = 16'h0010;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BUSY       = 2'd1,
        WAIT_STALL = 2'd2
    } state_t;

endpackage

// File: rtl/mmu_wb_master_timeout_cnt.sv
// wb_timeout_cnt
// Counts consecutive Wishbone wait cycles and flags the cycle in which the
// LIMIT-th wait cycle occurs. Only compiled when WB_TIMEOUT_EN is defined,
// which is also the only build that instantiates it.
//   clk     in  1  clock, rising edge
//   rst     in  1  asynchronous active-high reset
//   clr     in  1  restart counting (no cycle in progress, or it finished)
//   inc     in  1  one more wait cycle without acknowledge
//   expired out 1  this inc is the LIMIT-th in a row (combinational)
`ifdef WB_TIMEOUT_EN
module wb_timeout_cnt #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    // Count only reaches LIMIT-1 before it is cleared, so clog2(LIMIT) bits suffice.
    localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

    logic [CW-1:0] cnt;

    assign expired = inc & (cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || expired) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule
`endif

// File: rtl/mmu_wb_master.sv
// mmu_wb_master
// Turns one pipeline memory request (already translated by the TLB) into a
// single Wishbone classic cycle and stalls the pipeline until it completes.
//
// Handshake: a request is accepted in IDLE when cpu_ce_i=1, flush_i=0,
// tlb_exc_i=0 and tlb_select_i!=0; stallreq_o is high from that cycle until
// the cycle in which wb_ack_i arrives, where cpu_data_o carries the read data.
// wb_cyc_o and wb_stb_o are always identical (no block cycles).
//
// Optional feature: define WB_TIMEOUT_EN to abort a bus cycle after
// TIMEOUT_CYCLES wait cycles without acknowledge (bus_error_o pulses).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cpu_ce_i/we_i/addr_i/data_i/sel_i  pipeline request
//   tlb_select_i, tlb_exc_i  one-hot slave select (0 = unmapped), TLB exception
//   stall_i, flush_i         pipeline stall vector and flush
//   cpu_data_o, stallreq_o, bus_error_o  results back to the pipeline
//   wb_*                     Wishbone master interface, wb_slave_o = slave select
//   dbg_state                current controller state
module mmu_wb_master
    import mmu_wb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_ce_i,
    input  logic                  cpu_we_i,
    input  logic [WB_ADDR_W-1:0]  cpu_addr_i,
    input  logic [WB_DATA_W-1:0]  cpu_data_i,
    input  logic [WB_SEL_W-1:0]   cpu_sel_i,
    input  logic [WB_SLAVE_W-1:0] tlb_select_i,
    input  logic                  tlb_exc_i,
    input  logic [5:0]            stall_i,
    input  logic                  flush_i,
    output logic [WB_DATA_W-1:0]  cpu_data_o,
    output logic                  stallreq_o,
    output logic                  bus_error_o,
    output logic [WB_ADDR_W-1:0]  wb_adr_o,
    output logic [WB_DATA_W-1:0]  wb_dat_o,
    input  logic [WB_DATA_W-1:0]  wb_dat_i,
    output logic                  wb_we_o,
    output logic [WB_SEL_W-1:0]   wb_sel_o,
    output logic                  wb_stb_o,
    output logic                  wb_cyc_o,
    input  logic                  wb_ack_i,
    output logic [WB_SLAVE_W-1:0] wb_slave_o,
    output state_t                dbg_state
);

    state_t state, state_nxt;

    logic                 req_valid;
    logic                 req_unmapped;
    logic                 timeout;
    logic [WB_DATA_W-1:0] ack_data;
    logic [WB_DATA_W-1:0] rd_buf;

    assign req_valid    = cpu_ce_i & ~flush_i & ~tlb_exc_i & (tlb_select_i != '0);
    assign req_unmapped = cpu_ce_i & ~tlb_exc_i & (tlb_select_i == '0);
    // Writes hand back zero so the pipeline never sees stale bus data.
    assign ack_data     = wb_we_o ? ZeroWord : wb_dat_i;

`ifdef WB_TIMEOUT_EN
    logic to_inc, to_clr;

    assign to_inc = (state == BUSY) & ~wb_ack_i & ~flush_i;
    assign to_clr = (state != BUSY) | wb_ack_i | flush_i;

    wb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (to_clr),
        .inc     (to_inc),
        .expired (timeout)
    );
`else
    // Without the timeout feature BUSY waits for ack forever; the parameter
    // stays on the interface but has no effect.
    assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush wins over a simultaneous acknowledge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) state_nxt = BUSY;
            end
            BUSY: begin
                if (flush_i)       state_nxt = IDLE;
                else if (wb_ack_i) state_nxt = (stall_i != '0) ? WAIT_STALL : IDLE;
                else if (timeout)  state_nxt = IDLE;
            end
            WAIT_STALL: begin
                if (flush_i || stall_i == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pipeline-facing outputs
    always_comb begin
        cpu_data_o  = ZeroWord;
        stallreq_o  = 1'b0;
        bus_error_o = 1'b0;
        case (state)
            IDLE: begin
                stallreq_o  = req_valid;
                bus_error_o = req_unmapped;
            end
            BUSY: begin
                if (flush_i) begin
                    cpu_data_o = ZeroWord;
                end else if (wb_ack_i) begin
                    cpu_data_o = ack_data;
                end else if (timeout) begin
                    bus_error_o = 1'b1;
                end else begin
                    stallreq_o = 1'b1;
                end
            end
            WAIT_STALL: begin
                cpu_data_o = rd_buf;
            end
            default: ;
        endcase
        // Reset forces every output low even though IDLE still decodes inputs.
        if (rst) begin
            stallreq_o  = 1'b0;
            bus_error_o = 1'b0;
        end
    end

    // Bus-side registers: captured on acceptance, held for the whole cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_we_o    <= 1'b0;
            wb_sel_o   <= '0;
            wb_slave_o <= '0;
            wb_cyc_o   <= 1'b0;
            rd_buf     <= ZeroWord;
        end else if (state == IDLE && req_valid) begin
            wb_adr_o   <= cpu_addr_i;
            wb_dat_o   <= cpu_data_i;
            wb_we_o    <= cpu_we_i;
            wb_sel_o   <= cpu_sel_i;
            wb_slave_o <= tlb_select_i;
            wb_cyc_o   <= 1'b1;
        end else if (state == BUSY && (flush_i || wb_ack_i || timeout)) begin
            wb_cyc_o <= 1'b0;
            if (wb_ack_i && !flush_i) begin
                rd_buf <= ack_data;
            end
        end
    end

    assign wb_stb_o  = wb_cyc_o;
    assign dbg_state = state;

endmodule

// File: tb/tb_mmu_wb_master.sv
// tb_mmu_wb_master
// Directed bench for mmu_wb_master with a transaction-level reference model
// checked on every falling edge, plus literal expectations per scenario.
// Define WB_TIMEOUT_EN for both bench and RTL to exercise the timeout path.
module tb_mmu_wb_master;
    import mmu_wb_master_pkg::*;

    localparam int TO = 8;

    logic        clk, rst;
    logic        cpu_ce_i, cpu_we_i;
    logic [31:0] cpu_addr_i, cpu_data_i;
    logic [3:0]  cpu_sel_i;
    logic [15:0] tlb_select_i;
    logic        tlb_exc_i;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o, bus_error_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;
    logic [3:0]  wb_sel_o;
    logic [15:0] wb_slave_o;
    state_t      dbg_state;

    mmu_wb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_data_i(cpu_data_i), .cpu_sel_i(cpu_sel_i),
        .tlb_select_i(tlb_select_i), .tlb_exc_i(tlb_exc_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .cpu_data_o(cpu_data_o), .stallreq_o(stallreq_o), .bus_error_o(bus_error_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
        .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i), .wb_slave_o(wb_slave_o),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an outstanding transaction, a held result, wait count.
    bit          m_busy, m_hold;
    logic [31:0] m_adr, m_dat, m_buf;
    bit          m_we;
    logic [3:0]  m_sel;
    logic [15:0] m_slave;
    int          m_nwait;

    // Scenario tallies (written only by the compare process).
    int          n_cyc, n_err, n_stall, n_we, n_wait;
    logic [31:0] last_ack_data, last_wb_dat, last_adr, last_wait_data;

    initial begin
        m_busy = 0; m_hold = 0; m_buf = '0; m_nwait = 0;
        m_adr = '0; m_dat = '0; m_we = 0; m_sel = '0; m_slave = '0;
        n_cyc = 0; n_err = 0; n_stall = 0; n_we = 0; n_wait = 0;
        last_ack_data = '1; last_wb_dat = '0; last_adr = '0; last_wait_data = '0;
    end

    always @(negedge clk) begin : compare
        logic [31:0] e_data;
        bit          e_stall, e_err, to_fire, valid;
        state_t      e_state;
        if (rst) begin
            chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
            chk("rst_stb", 32'(wb_stb_o), 32'd0);
            chk("rst_stallreq", 32'(stallreq_o), 32'd0);
            chk("rst_bus_error", 32'(bus_error_o), 32'd0);
            chk("rst_cpu_data", cpu_data_o, 32'd0);
            chk("rst_wb_adr", wb_adr_o, 32'd0);
            chk("rst_state", 32'(dbg_state), 32'(IDLE));
            m_busy = 0; m_hold = 0; m_buf = '0; m_nwait = 0;
        end else begin
            e_data = 32'd0; e_stall = 0; e_err = 0; to_fire = 0;
            valid = cpu_ce_i && !flush_i && !tlb_exc_i && (tlb_select_i != 16'd0);
`ifdef WB_TIMEOUT_EN
            to_fire = m_busy && !flush_i && !wb_ack_i && (m_nwait == TO - 1);
`endif
            e_state = m_busy ? BUSY : (m_hold ? WAIT_STALL : IDLE);
            if (!m_busy && !m_hold) begin
                e_stall = valid;
                e_err   = cpu_ce_i && !tlb_exc_i && (tlb_select_i == 16'd0);
            end else if (m_busy) begin
                if (flush_i)       e_data = 32'd0;
                else if (wb_ack_i) e_data = m_we ? 32'd0 : wb_dat_i;
                else if (to_fire)  e_err = 1;
                else               e_stall = 1;
            end else begin
                e_data = m_buf;
            end

            chk("cyc", 32'(wb_cyc_o), 32'(m_busy));
            chk("stb", 32'(wb_stb_o), 32'(m_busy));
            chk("stallreq", 32'(stallreq_o), 32'(e_stall));
            chk("bus_error", 32'(bus_error_o), 32'(e_err));
            chk("cpu_data", cpu_data_o, e_data);
            chk("state", 32'(dbg_state), 32'(e_state));
            if (m_busy) begin
                chk("wb_adr", wb_adr_o, m_adr);
                chk("wb_dat_o", wb_dat_o, m_dat);
                chk("wb_we", 32'(wb_we_o), 32'(m_we));
                chk("wb_sel", 32'(wb_sel_o), 32'(m_sel));
                chk("wb_slave", 32'(wb_slave_o), 32'(m_slave));
            end

            // Advance the model to what must hold after the next rising edge.
            if (!m_busy && !m_hold) begin
                if (valid) begin
                    m_busy = 1; m_nwait = 0;
                    m_adr = cpu_addr_i; m_dat = cpu_data_i; m_we = cpu_we_i;
                    m_sel = cpu_sel_i; m_slave = tlb_select_i;
                end
            end else if (m_busy) begin
                if (flush_i) begin
                    m_busy = 0;
                end else if (wb_ack_i) begin
                    m_busy = 0;
                    m_buf  = m_we ? 32'd0 : wb_dat_i;
                    m_hold = (stall_i != 6'd0);
                end else if (to_fire) begin
                    m_busy = 0;
                end else begin
                    m_nwait++;
                end
            end else if (flush_i || stall_i == 6'd0) begin
                m_hold = 0;
            end
        end

        if (wb_cyc_o) begin
            n_cyc++;
            last_wb_dat = wb_dat_o;
            last_adr    = wb_adr_o;
            if (wb_we_o) n_we++;
            if (wb_ack_i) last_ack_data = cpu_data_o;
        end
        if (bus_error_o) n_err++;
        if (stallreq_o) n_stall++;
        if (dbg_state == WAIT_STALL) begin
            n_wait++;
            last_wait_data = cpu_data_o;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_ce_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_data_i = '0; cpu_sel_i = '0;
        tlb_select_i = '0; tlb_exc_i = 0; stall_i = '0; flush_i = 0;
        wb_ack_i = 0; wb_dat_i = $urandom;
    endtask

    // One request, 'waits' cycles without ack, ack with 'rdata'; stall_v is
    // presented in the ack cycle and 'hold' cycles after it.
    task automatic run_txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [15:0] slv, input int waits,
                           input logic [31:0] rdata, input logic [5:0] stall_v, input int hold);
        cpu_ce_i = 1; cpu_we_i = w; cpu_addr_i = a; cpu_data_i = d;
        cpu_sel_i = s; tlb_select_i = slv;
        step();
        cpu_ce_i = 0; cpu_addr_i = $urandom; cpu_data_i = $urandom;
        repeat (waits) begin
            wb_dat_i = $urandom;
            step();
        end
        wb_ack_i = 1; wb_dat_i = rdata; stall_i = stall_v;
        step();
        wb_ack_i = 0; wb_dat_i = $urandom;
        repeat (hold) step();
        stall_i = '0;
        step();
        step();
    endtask

    int b_cyc, b_err, b_stall, b_we, b_wait;

    task automatic snap();
        b_cyc = n_cyc; b_err = n_err; b_stall = n_stall; b_we = n_we; b_wait = n_wait;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1;
        idle_inputs();
        repeat (3) step();
        rst = 0;
        step();

        // Read from RAM, three wait states, no stall.
        snap();
        run_txn(0, 32'h0000_0100, 32'h0, 4'hF, WB_SELECT_RAM, 3, 32'hCAFE_0001, 6'd0, 0);
        chk("rd_cyc_cycles", 32'(n_cyc - b_cyc), 32'd4);
        chk("rd_ack_data", last_ack_data, 32'hCAFE_0001);
        chk("rd_stall_cycles", 32'(n_stall - b_stall), 32'd4);
        chk("rd_adr", last_adr, 32'h0000_0100);

        // Write to UART, immediate ack: two-cycle latency, zero data back.
        snap();
        run_txn(1, 32'h1FD0_03F8, 32'hDEAD_BEEF, 4'hF, WB_SELECT_UART, 0, 32'h5555_AAAA, 6'd0, 0);
        chk("wr_we_cycles", 32'(n_we - b_we), 32'd1);
        chk("wr_wb_dat", last_wb_dat, 32'hDEAD_BEEF);
        chk("wr_latency", 32'(n_stall - b_stall + 1), 32'd2);
        chk("wr_ack_data", last_ack_data, 32'd0);

        // Read acked under stall: result held in WAIT_STALL for two cycles.
        snap();
        run_txn(0, 32'h0000_0204, 32'h0, 4'b0011, WB_SELECT_GPIO, 1, 32'h1234_5678, 6'b000011, 1);
        chk("stl_wait_cycles", 32'(n_wait - b_wait), 32'd2);
        chk("stl_wait_data", last_wait_data, 32'h1234_5678);
        chk("stl_idle_after", 32'(dbg_state), 32'(IDLE));

        // Unmapped address: error pulse, no bus cycle.
        snap();
        cpu_ce_i = 1; tlb_select_i = 16'd0; cpu_addr_i = 32'h8000_0000;
        step();
        cpu_ce_i = 0;
        step(); step();
        chk("unm_cyc", 32'(n_cyc - b_cyc), 32'd0);
        chk("unm_err_pulses", 32'(n_err - b_err), 32'd1);

        // TLB exception: neither bus cycle nor error nor stall.
        snap();
        cpu_ce_i = 1; tlb_exc_i = 1; tlb_select_i = WB_SELECT_RAM;
        step();
        cpu_ce_i = 0; tlb_exc_i = 0;
        step(); step();
        chk("exc_cyc", 32'(n_cyc - b_cyc), 32'd0);
        chk("exc_err", 32'(n_err - b_err), 32'd0);
        chk("exc_stall", 32'(n_stall - b_stall), 32'd0);

        // Flush together with ack: flush wins, data discarded.
        snap();
        cpu_ce_i = 1; cpu_we_i = 0; cpu_addr_i = 32'h0000_0300; cpu_sel_i = 4'hF;
        tlb_select_i = WB_SELECT_RAM;
        step();
        cpu_ce_i = 0;
        step();
        wb_ack_i = 1; flush_i = 1; wb_dat_i = 32'hBAD0_BAD0;
        step();
        wb_ack_i = 0; flush_i = 0;
        step(); step();
        chk("fl_cyc_cycles", 32'(n_cyc - b_cyc), 32'd2);
        chk("fl_ack_data", last_ack_data, 32'd0);
        chk("fl_state", 32'(dbg_state), 32'(IDLE));

        // Reset while BUSY: cyc drops at once and the transfer is not retried.
        cpu_ce_i = 1; cpu_addr_i = 32'h0000_0400; tlb_select_i = WB_SELECT_ROM;
        step();
        cpu_ce_i = 0;
        step();
        chk("rb_cyc_before", 32'(wb_cyc_o), 32'd1);
        #2 rst = 1;
        #1;
        chk("rb_cyc_async", 32'(wb_cyc_o), 32'd0);
        chk("rb_stb_async", 32'(wb_stb_o), 32'd0);
        step(); step();
        rst = 0;
        snap();
        repeat (3) step();
        chk("rb_no_retry", 32'(n_cyc - b_cyc), 32'd0);

`ifdef WB_TIMEOUT_EN
        // No ack: bus cycle abandoned after TO wait cycles with one error pulse.
        snap();
        cpu_ce_i = 1; cpu_addr_i = 32'h0000_0500; tlb_select_i = WB_SELECT_TIMER;
        step();
        cpu_ce_i = 0;
        repeat (TO + 2) step();
        chk("to_cyc_cycles", 32'(n_cyc - b_cyc), 32'd8);
        chk("to_err_pulses", 32'(n_err - b_err), 32'd1);
        chk("to_state", 32'(dbg_state), 32'(IDLE));
`endif

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
